dmem_arbiter: RTL and testbench
===============================

// Module: dmem_arbiter
// PURPOSE
//  Shares the single-port 16 KB data memory (4096 x 32, async read, byte-masked sync write)
//  between the CPU load/store port and a secondary master (UART loader / sensor DMA).
//  The CPU has priority. A wait counter bounds DMA starvation by stealing one CPU cycle.
//  DMA accesses outside the DMEM window are rejected. Sits between core Execution stage and my_dmem.
// PARAMETERS
//  MAX_WAIT   8             cycles a pending DMA request may be blocked before a forced grant (1..255)
//  BASE_ADDR  32'h1000_0000 byte base of the DMEM window (DMA range check only)
//  ADDR_BITS  14            log2 window size in bytes (16 KB)
// PORTS
//  clk           in   1   system clock
//  rst           in   1   synchronous, active-high reset
//  cpu_req_i     in   1   CPU load/store valid this cycle
//  cpu_we_i      in   1   CPU write enable
//  cpu_wmask_i   in   4   CPU byte mask
//  cpu_addr_i    in   32  CPU byte address
//  cpu_wdata_i   in   32  CPU write data
//  cpu_rdata_o   out  32  CPU read data (combinational from memory)
//  cpu_stall_o   out  1   CPU access not served this cycle; CPU holds request
//  dma_req_i     in   1   DMA request; held with stable fields until dma_gnt_o
//  dma_we_i      in   1   DMA write enable
//  dma_wmask_i   in   4   DMA byte mask
//  dma_addr_i    in   32  DMA byte address
//  dma_wdata_i   in   32  DMA write data
//  dma_gnt_o     out  1   DMA access accepted this cycle (1-cycle pulse per access)
//  dma_rvalid_o  out  1   registered read data valid (cycle after a read grant)
//  dma_rdata_o   out  32  registered DMA read data
//  dma_err_o     out  1   registered: last granted DMA access was out of window (no write done)
//  mem_we_o      out  1   to DMEM we_i
//  mem_wmask_o   out  4   to DMEM wmask_i
//  mem_addr_o    out  32  to DMEM addr_i
//  mem_wdata_o   out  32  to DMEM data_i
//  mem_rdata_i   in   32  from DMEM data_o
// BEHAVIOUR
//  - Per-cycle select (combinational): sel_dma = dma_req_i & (~cpu_req_i | wait_cnt == MAX_WAIT).
//  - sel_dma=0: mem_* = cpu_*; mem_we_o = cpu_req_i & cpu_we_i; cpu_stall_o = 0.
//  - sel_dma=1: mem_addr/wmask/wdata = dma_*; mem_we_o = dma_we_i & in_window; dma_gnt_o = 1;
//    cpu_stall_o = cpu_req_i. Stalled CPU retries next cycle, is then served (wait_cnt is 0).
//  - in_window = (dma_addr_i[31:ADDR_BITS] == BASE_ADDR[31:ADDR_BITS]). CPU is never range-checked.
//  - wait_cnt (8b): reset 0; ->0 on sel_dma or ~dma_req_i; +1 when dma_req_i & cpu_req_i & ~sel_dma;
//    saturates at MAX_WAIT. A continuously busy CPU therefore yields 1 of every MAX_WAIT+1 cycles.
//  - One DMA access per grant. A back-to-back DMA request with CPU idle is granted every cycle.
//  - Read return: on a grant with ~dma_we_i, the next cycle dma_rvalid_o=1 and
//    dma_rdata_o=mem_rdata_i. Out-of-window read returns 32'h0. rvalid is 0 otherwise.
//    rdata holds its last value.
//  - dma_err_o: updated on every DMA grant to ~in_window; holds between grants.
//  - Reset: wait_cnt=0, dma_rvalid_o=0, dma_rdata_o=0, dma_err_o=0. Combinational outputs follow
//    their inputs during reset with sel_dma forced 0 and mem_we_o forced 0.
//    Reset mid-access drops the pending read return (rvalid stays 0).
//  - cpu_rdata_o = mem_rdata_i always. Valid only when cpu_req_i & ~cpu_stall_o.
// TESTING
//  1 CPU only: cpu write 0xDEADBEEF @0x10000010 mask F, then read -> cpu_rdata_o=0xDEADBEEF,
//    stall never high.
//  2 DMA only: dma write 0x12345678 @0x10000020, gnt same cycle; dma read ->
//    rvalid next cycle, rdata=0x12345678.
//  3 Contention: cpu_req held high, dma_req high, MAX_WAIT=8 -> gnt on 9th cycle,
//    stall 1 cycle, wait_cnt back to 0.
//  4 Byte mask via DMA: write 0xAABBCCDD mask 4'b0101 over 0 -> readback 0x00BB00DD.
//  5 Out of window: dma write @0x20000000 -> gnt=1, mem_we_o=0, dma_err_o=1 next cycle,
//    memory unchanged; read returns 0.
//  6 Reset: assert rst the cycle after a DMA read grant -> rvalid stays 0, wait_cnt=0,
//    mem_we_o=0 during reset.

Source files
------------

// File: rtl/dmem_arbiter.sv
// Shares the single-port data memory between the CPU load/store port (priority) and a DMA master.
// Memory path is combinational; DMA read data, rvalid and error status are registered one cycle after grant.
module dmem_arbiter #(
  parameter int unsigned MAX_WAIT  = 8,
  parameter logic [31:0] BASE_ADDR = 32'h1000_0000,
  parameter int unsigned ADDR_BITS = 14
) (
  input  logic        clk,
  input  logic        rst,

  input  logic        cpu_req_i,
  input  logic        cpu_we_i,
  input  logic [3:0]  cpu_wmask_i,
  input  logic [31:0] cpu_addr_i,
  input  logic [31:0] cpu_wdata_i,
  output logic [31:0] cpu_rdata_o,
  output logic        cpu_stall_o,

  input  logic        dma_req_i,
  input  logic        dma_we_i,
  input  logic [3:0]  dma_wmask_i,
  input  logic [31:0] dma_addr_i,
  input  logic [31:0] dma_wdata_i,
  output logic        dma_gnt_o,
  output logic        dma_rvalid_o,
  output logic [31:0] dma_rdata_o,
  output logic        dma_err_o,

  output logic        mem_we_o,
  output logic [3:0]  mem_wmask_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic [31:0] mem_rdata_i
);

  localparam logic [7:0] MAX_WAIT_C = 8'(MAX_WAIT);

  logic [7:0]  wait_cnt_q, wait_cnt_d;
  logic        rvalid_q, rvalid_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic        in_window;
  logic        wait_at_max;
  logic        sel_dma;

  assign in_window   = (dma_addr_i[31:ADDR_BITS] == BASE_ADDR[31:ADDR_BITS]);
  assign wait_at_max = (wait_cnt_q == MAX_WAIT_C);
  assign sel_dma     = ~rst & dma_req_i & (~cpu_req_i | wait_at_max);

  always_comb begin
    mem_addr_o  = cpu_addr_i;
    mem_wmask_o = cpu_wmask_i;
    mem_wdata_o = cpu_wdata_i;
    mem_we_o    = ~rst & cpu_req_i & cpu_we_i;
    cpu_stall_o = 1'b0;
    dma_gnt_o   = 1'b0;
    if (sel_dma) begin
      mem_addr_o  = dma_addr_i;
      mem_wmask_o = dma_wmask_i;
      mem_wdata_o = dma_wdata_i;
      mem_we_o    = dma_we_i & in_window;
      cpu_stall_o = cpu_req_i;
      dma_gnt_o   = 1'b1;
    end
  end

  assign cpu_rdata_o = mem_rdata_i;

  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (sel_dma || !dma_req_i) begin
      wait_cnt_d = 8'd0;
    end else if (cpu_req_i && !wait_at_max) begin
      wait_cnt_d = wait_cnt_q + 8'd1;
    end
  end

  // Out-of-window reads must not leak whatever word the aliased low address bits select.
  always_comb begin
    rvalid_d = sel_dma & ~dma_we_i;
    rdata_d  = rdata_q;
    err_d    = err_q;
    if (sel_dma) begin
      err_d = ~in_window;
      if (!dma_we_i) begin
        rdata_d = in_window ? mem_rdata_i : 32'h0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt_q <= 8'd0;
      rvalid_q   <= 1'b0;
      rdata_q    <= 32'h0;
      err_q      <= 1'b0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
      rvalid_q   <= rvalid_d;
      rdata_q    <= rdata_d;
      err_q      <= err_d;
    end
  end

  // A reset landing in the return cycle squashes the in-flight read immediately.
  assign dma_rvalid_o = rvalid_q & ~rst;
  assign dma_rdata_o  = rdata_q;
  assign dma_err_o    = err_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural 4096x32 memory attached to the mem_* port.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_req, cpu_we, dma_req, dma_we;
  logic [3:0]  cpu_wmask, dma_wmask;
  logic [31:0] cpu_addr, cpu_wdata, dma_addr, dma_wdata;
  logic [31:0] cpu_rdata, dma_rdata;
  logic        cpu_stall, dma_gnt, dma_rvalid, dma_err;
  logic        mem_we;
  logic [3:0]  mem_wmask;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  logic [31:0] tb_mem [4096];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  dmem_arbiter dut (
    .clk(clk), .rst(rst),
    .cpu_req_i(cpu_req), .cpu_we_i(cpu_we), .cpu_wmask_i(cpu_wmask),
    .cpu_addr_i(cpu_addr), .cpu_wdata_i(cpu_wdata),
    .cpu_rdata_o(cpu_rdata), .cpu_stall_o(cpu_stall),
    .dma_req_i(dma_req), .dma_we_i(dma_we), .dma_wmask_i(dma_wmask),
    .dma_addr_i(dma_addr), .dma_wdata_i(dma_wdata),
    .dma_gnt_o(dma_gnt), .dma_rvalid_o(dma_rvalid), .dma_rdata_o(dma_rdata), .dma_err_o(dma_err),
    .mem_we_o(mem_we), .mem_wmask_o(mem_wmask), .mem_addr_o(mem_addr),
    .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata)
  );

  assign mem_rdata = tb_mem[mem_addr[13:2]];

  always @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (mem_wmask[b]) tb_mem[mem_addr[13:2]][b*8 +: 8] <= mem_wdata[b*8 +: 8];
      end
    end
  end

  typedef struct {
    logic        creq, cwe;
    logic [3:0]  cmask;
    logic [31:0] caddr, cwdata;
    logic        dreq, dwe;
    logic [3:0]  dmask;
    logic [31:0] daddr, dwdata;
    logic        x_stall, x_gnt, x_mwe, chk_crd;
    logic [31:0] x_crd;
    logic        x_rvld;
    logic [31:0] x_rdata;
    logic        x_err;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t v(input logic creq, input logic cwe, input logic [3:0] cmask,
                             input logic [31:0] caddr, input logic [31:0] cwdata,
                             input logic dreq, input logic dwe, input logic [3:0] dmask,
                             input logic [31:0] daddr, input logic [31:0] dwdata,
                             input logic x_stall, input logic x_gnt, input logic x_mwe,
                             input logic chk_crd, input logic [31:0] x_crd,
                             input logic x_rvld, input logic [31:0] x_rdata, input logic x_err);
    vec_t r;
    r.creq = creq; r.cwe = cwe; r.cmask = cmask; r.caddr = caddr; r.cwdata = cwdata;
    r.dreq = dreq; r.dwe = dwe; r.dmask = dmask; r.daddr = daddr; r.dwdata = dwdata;
    r.x_stall = x_stall; r.x_gnt = x_gnt; r.x_mwe = x_mwe; r.chk_crd = chk_crd; r.x_crd = x_crd;
    r.x_rvld = x_rvld; r.x_rdata = x_rdata; r.x_err = x_err;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input logic creq, input logic cwe, input logic [31:0] caddr,
                       input logic [31:0] cwdata, input logic dreq, input logic dwe,
                       input logic [31:0] daddr);
    cpu_req = creq; cpu_we = cwe; cpu_wmask = 4'hF; cpu_addr = caddr; cpu_wdata = cwdata;
    dma_req = dreq; dma_we = dwe; dma_wmask = 4'hF; dma_addr = daddr; dma_wdata = 32'h0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) tb_mem[i] = 32'h0;
    rst = 1'b1;
    // reset: CPU write and DMA request present but nothing may be granted or written
    drive(1'b1, 1'b1, 32'h1000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0, 32'h1000_0020);
    tick();
    @(negedge clk);
    chk("rst_mem_we", 32'(mem_we), 32'h0);
    chk("rst_gnt", 32'(dma_gnt), 32'h0);
    chk("rst_stall", 32'(cpu_stall), 32'h0);
    chk("rst_mem_addr", mem_addr, 32'h1000_0000);
    chk("rst_rvalid", 32'(dma_rvalid), 32'h0);
    chk("rst_rdata", dma_rdata, 32'h0);
    chk("rst_err", 32'(dma_err), 32'h0);
    tick();
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
    rst = 1'b0;

    // creq cwe cmask caddr cwdata | dreq dwe dmask daddr dwdata | stall gnt mwe chk crd | rvld rdata err
    vecs.push_back(v(1,1,4'hF,32'h1000_0010,32'hDEAD_BEEF, 0,0,4'h0,32'h0,32'h0,               0,0,1, 1,32'h0,        0,32'h0,0));
    vecs.push_back(v(1,0,4'h0,32'h1000_0010,32'h0,         0,0,4'h0,32'h0,32'h0,               0,0,0, 1,32'hDEAD_BEEF,0,32'h0,0));
    vecs.push_back(v(0,0,4'h0,32'h0,32'h0,                 1,1,4'hF,32'h1000_0020,32'h1234_5678,0,1,1, 0,32'h0,        0,32'h0,0));
    vecs.push_back(v(0,0,4'h0,32'h0,32'h0,                 1,0,4'h0,32'h1000_0020,32'h0,       0,1,0, 0,32'h0,        0,32'h0,0));
    vecs.push_back(v(0,0,4'h0,32'h0,32'h0,                 0,0,4'h0,32'h0,32'h0,               0,0,0, 0,32'h0,        1,32'h1234_5678,0));
    vecs.push_back(v(0,0,4'h0,32'h0,32'h0,                 1,1,4'h5,32'h1000_0030,32'hAABB_CCDD,0,1,1, 0,32'h0,        0,32'h1234_5678,0));
    vecs.push_back(v(0,0,4'h0,32'h0,32'h0,                 1,0,4'h0,32'h1000_0030,32'h0,       0,1,0, 0,32'h0,        0,32'h1234_5678,0));
    vecs.push_back(v(0,0,4'h0,32'h0,32'h0,                 0,0,4'h0,32'h0,32'h0,               0,0,0, 0,32'h0,        1,32'h00BB_00DD,0));
    vecs.push_back(v(0,0,4'h0,32'h0,32'h0,                 1,1,4'hF,32'h2000_0000,32'hCAFE_F00D,0,1,0, 0,32'h0,        0,32'h00BB_00DD,0));
    vecs.push_back(v(0,0,4'h0,32'h0,32'h0,                 1,0,4'h0,32'h2000_0000,32'h0,       0,1,0, 0,32'h0,        0,32'h00BB_00DD,1));
    vecs.push_back(v(0,0,4'h0,32'h0,32'h0,                 0,0,4'h0,32'h0,32'h0,               0,0,0, 0,32'h0,        1,32'h0,       1));
    vecs.push_back(v(1,0,4'h0,32'h1000_0000,32'h0,         0,0,4'h0,32'h0,32'h0,               0,0,0, 1,32'h0,        0,32'h0,       1));
    vecs.push_back(v(1,0,4'h0,32'h1000_0010,32'h0,         1,0,4'h0,32'h1000_0020,32'h0,       0,0,0, 1,32'hDEAD_BEEF,0,32'h0,       1));
    vecs.push_back(v(0,0,4'h0,32'h0,32'h0,                 1,0,4'h0,32'h1000_0020,32'h0,       0,1,0, 0,32'h0,        0,32'h0,       1));
    vecs.push_back(v(0,0,4'h0,32'h0,32'h0,                 0,0,4'h0,32'h0,32'h0,               0,0,0, 0,32'h0,        1,32'h1234_5678,0));

    foreach (vecs[i]) begin
      cpu_req = vecs[i].creq; cpu_we = vecs[i].cwe; cpu_wmask = vecs[i].cmask;
      cpu_addr = vecs[i].caddr; cpu_wdata = vecs[i].cwdata;
      dma_req = vecs[i].dreq; dma_we = vecs[i].dwe; dma_wmask = vecs[i].dmask;
      dma_addr = vecs[i].daddr; dma_wdata = vecs[i].dwdata;
      @(negedge clk);
      chk($sformatf("v%0d_stall", i), 32'(cpu_stall), 32'(vecs[i].x_stall));
      chk($sformatf("v%0d_gnt", i), 32'(dma_gnt), 32'(vecs[i].x_gnt));
      chk($sformatf("v%0d_mem_we", i), 32'(mem_we), 32'(vecs[i].x_mwe));
      chk($sformatf("v%0d_mem_addr", i), mem_addr, vecs[i].x_gnt ? vecs[i].daddr : vecs[i].caddr);
      if (vecs[i].chk_crd) chk($sformatf("v%0d_cpu_rdata", i), cpu_rdata, vecs[i].x_crd);
      chk($sformatf("v%0d_rvalid", i), 32'(dma_rvalid), 32'(vecs[i].x_rvld));
      chk($sformatf("v%0d_rdata", i), dma_rdata, vecs[i].x_rdata);
      chk($sformatf("v%0d_err", i), 32'(dma_err), 32'(vecs[i].x_err));
      tick();
    end

    // contention: a busy CPU yields exactly one cycle in nine
    drive(1'b1, 1'b0, 32'h1000_0010, 32'h0, 1'b1, 1'b0, 32'h1000_0020);
    for (int k = 0; k < 18; k++) begin
      @(negedge clk);
      chk($sformatf("cont%0d_gnt", k), 32'(dma_gnt), 32'(k == 8 || k == 17));
      chk($sformatf("cont%0d_stall", k), 32'(cpu_stall), 32'(k == 8 || k == 17));
      chk($sformatf("cont%0d_rvalid", k), 32'(dma_rvalid), 32'(k == 9));
      if (k == 9) chk("cont_rdata", dma_rdata, 32'h1234_5678);
      tick();
    end
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
    tick();

    // reset in the middle of a partial wait count must restart the count from zero
    drive(1'b1, 1'b0, 32'h1000_0010, 32'h0, 1'b1, 1'b0, 32'h1000_0020);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk($sformatf("pre%0d_gnt", k), 32'(dma_gnt), 32'h0);
      tick();
    end
    rst = 1'b1;
    drive(1'b1, 1'b1, 32'h1000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0, 32'h1000_0020);
    @(negedge clk);
    chk("mid_rst_mem_we", 32'(mem_we), 32'h0);
    chk("mid_rst_gnt", 32'(dma_gnt), 32'h0);
    tick();
    rst = 1'b0;
    drive(1'b1, 1'b0, 32'h1000_0010, 32'h0, 1'b1, 1'b0, 32'h1000_0020);
    for (int k = 0; k < 9; k++) begin
      @(negedge clk);
      chk($sformatf("post%0d_gnt", k), 32'(dma_gnt), 32'(k == 8));
      tick();
    end
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
    tick();

    // reset in the return cycle of a DMA read drops the return
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h1000_0030);
    @(negedge clk);
    chk("rr_gnt", 32'(dma_gnt), 32'h1);
    tick();
    rst = 1'b1;
    drive(1'b1, 1'b1, 32'h1000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    chk("rr_rvalid_in_rst", 32'(dma_rvalid), 32'h0);
    chk("rr_mem_we_in_rst", 32'(mem_we), 32'h0);
    tick();
    rst = 1'b0;
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    chk("rr_rvalid_after", 32'(dma_rvalid), 32'h0);
    chk("rr_rdata_after", dma_rdata, 32'h0);
    chk("rr_err_after", 32'(dma_err), 32'h0);
    tick();
    drive(1'b1, 1'b0, 32'h1000_0000, 32'h0, 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    chk("rr_mem_untouched", cpu_rdata, 32'h0);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
